matrix_server: RTL
==================

// Module: matrix_server
// PURPOSE
//  Responder end of the matrix row/column fetch protocol used by the matrix algorithm blocks.
//  Holds matrices A (row-major) and B (column-major) in internal storage. Storage is loaded over an
//  element write port, then each request (new_request, row_req, col_req) is answered with the full
//  A row, the full B column, the echoed indices and a one-cycle val_rows strobe.
//  Sits between the load path (UART/BRAM loader) and the compute algorithm.
// PARAMETERS
//  N   32  matrix dimension (rows = cols = N)
//  DW  8   element width in bits
//  IW  5   index width, = $clog2(N)
// PORTS
//  clk_in       in   1          system clock; all logic on the rising edge
//  rst_in       in   1          reset, asynchronous, active-low
//  wr_en        in   1          element write strobe, load phase only
//  wr_sel       in   1          0 = write A, 1 = write B
//  wr_row       in   IW         element row index
//  wr_col       in   IW         element column index
//  wr_data      in   DW         element value
//  load_last    in   1          pulse: loading finished, enter serve phase
//  load_clear   in   1          pulse: leave serve phase, return to load phase
//  new_request  in   1          requester has a valid request
//  row_req      in   IW         requested A row
//  col_req      in   IW         requested B column
//  complete     out  1          high while in serve phase
//  matA_row     out  [N-1:0][DW-1:0]  A[row_in][*]
//  matB_col     out  [N-1:0][DW-1:0]  B[*][col_in]
//  row_in       out  IW         echoed row_req
//  col_in       out  IW         echoed col_req
//  val_rows     out  1          one-cycle strobe: response outputs valid
//  wr_err       out  1          sticky: write attempted during serve phase
// BEHAVIOUR
//  Reset (rst_in=0, async): complete, val_rows and wr_err = 0; row_in, col_in, matA_row and matB_col = 0;
//   FSM = LOAD. Matrix storage is NOT reset.
//  LOAD state:
//   - wr_en=1: writes wr_data to A[wr_row][wr_col] (wr_sel=0) or B[wr_row][wr_col] (wr_sel=1). Write is visible next cycle.
//   - new_request is ignored.
//   - load_last=1 -> IDLE. complete rises in the same clock edge.
//   - If wr_en and load_last are both high in one cycle, the write is performed first, then the transition.
//  IDLE state: new_request=1 -> FETCH. row_req and col_req are latched into internal address registers.
//  FETCH state: storage is read at the latched addresses -> RESP.
//  RESP state:
//   - val_rows=1 for exactly this cycle.
//   - matA_row, matB_col, row_in and col_in are registered and held stable until the next RESP.
//   - Next state -> GAP.
//  GAP state: one dead cycle so the requester's updated row_req/col_req is visible -> IDLE.
//  Timing: request sampled in IDLE at edge T gives val_rows high in cycle T+2. Peak rate is 1 response per 4 cycles.
//  new_request held high continuously is legal; each IDLE visit serves the values present at that edge.
//  Serve phase (IDLE/FETCH/RESP/GAP):
//   - wr_en=1 is dropped and sets wr_err; only reset clears wr_err.
//   - load_clear=1 -> LOAD next edge and complete=0. An in-flight response is aborted: no val_rows.
//   - load_last is ignored.
//  Indices are IW bits, so no out-of-range access is possible; wrap is the requester's responsibility.
//  Reset mid-response: val_rows drops immediately (async); FSM restarts in LOAD; storage contents are kept.
// CONFIGURATION
//  MATRIX_SERVER_REQCNT_EN defined:
//   - adds output req_count [15:0], reset 0.
//   - increments once per RESP cycle and saturates at 16'hFFFF.
//   - cleared on load_clear.
//  MATRIX_SERVER_REQCNT_EN undefined: the port and the counter are absent. All other behaviour is identical.
// TESTING
//  1. Reset, then load A[i][j]=i+j and B[i][j]=i*j (mod 256), pulse load_last -> complete=1 next cycle, wr_err=0.
//  2. Request row_req=3, col_req=7 -> val_rows exactly 2 cycles later, row_in=3, col_in=7,
//     matA_row[5]=8, matB_col[4]=28.
//  3. Drive the dummy_alg-style walk (new_request held, indices advanced on each val_rows) over 0..31 x 0..31
//     -> 1024 val_rows pulses, each echo matching the request.
//  4. wr_en=1 during serve, wr_row=0, wr_col=0, wr_data=8'hFF -> wr_err=1 and A[0][0] still reads 0.
//  5. load_clear in FETCH -> no val_rows, complete=0 next cycle; reload, then load_last -> serving resumes correctly.
//  6. rst_in low mid-RESP -> val_rows=0 asynchronously; with REQCNT_EN, req_count=0 after reset and
//     req_count=1024 after scenario 3.

Source files
------------

// File: rtl/matrix_server.sv
// matrix_server: responder end of the matrix row/column fetch protocol.
//
// Holds matrix A (row-major) and B (column-major) in internal storage. The storage is filled over an
// element write port while in the load phase; in the serve phase each request is answered with a
// full A row, a full B column, the echoed indices and a one-cycle val_rows strobe.
//
// Ports:
//   clk_in, rst_in       clock (rising edge), asynchronous active-low reset
//   wr_en/wr_sel/wr_row/wr_col/wr_data
//                        element write port; wr_sel 0 = A, 1 = B; load phase only
//   load_last            pulse: loading finished, enter serve phase
//   load_clear           pulse: leave serve phase, return to load phase
//   new_request, row_req, col_req
//                        request handshake from the compute algorithm
//   complete             high while in serve phase
//   matA_row, matB_col   A[row_in][*] and B[*][col_in]
//   row_in, col_in       echoed request indices
//   val_rows             one-cycle strobe: response outputs valid
//   wr_err               sticky: write attempted during serve phase
//   req_count            (MATRIX_SERVER_REQCNT_EN only) saturating response counter
//
// Configuration macro: MATRIX_SERVER_REQCNT_EN adds the req_count output and its counter.

`timescale 1ns/1ps

module matrix_server #(
   parameter int unsigned N  = 32,
   parameter int unsigned DW = 8,
   parameter int unsigned IW = 5
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  wr_en,
   input  logic                  wr_sel,
   input  logic [IW-1:0]         wr_row,
   input  logic [IW-1:0]         wr_col,
   input  logic [DW-1:0]         wr_data,
   input  logic                  load_last,
   input  logic                  load_clear,
   input  logic                  new_request,
   input  logic [IW-1:0]         row_req,
   input  logic [IW-1:0]         col_req,
   output logic                  complete,
   output logic [N-1:0][DW-1:0]  matA_row,
   output logic [N-1:0][DW-1:0]  matB_col,
   output logic [IW-1:0]         row_in,
   output logic [IW-1:0]         col_in,
   output logic                  val_rows,
   output logic                  wr_err
`ifdef MATRIX_SERVER_REQCNT_EN
   ,
   output logic [15:0]           req_count
`endif
);

   typedef enum logic [2:0] {
      StLoad,
      StIdle,
      StFetch,
      StResp,
      StGap
   } state_e;

   state_e r_state;

   // A is stored by row and B by column so that each response is a single word read.
   logic [N-1:0][DW-1:0] r_mem_a [N];
   logic [N-1:0][DW-1:0] r_mem_b [N];

   logic [IW-1:0]        r_row_addr;
   logic [IW-1:0]        r_col_addr;
   logic                 r_complete;
   logic                 r_val_rows;
   logic                 r_wr_err;
   logic [IW-1:0]        r_row_in;
   logic [IW-1:0]        r_col_in;
   logic [N-1:0][DW-1:0] r_mat_a;
   logic [N-1:0][DW-1:0] r_mat_b;

   logic                 w_load_wr;

   assign w_load_wr = wr_en && (r_state == StLoad);

   // Storage has no reset so contents survive a reset.
   always_ff @(posedge clk_in) begin
      if (w_load_wr) begin
         if (!wr_sel) begin
            r_mem_a[wr_row][wr_col] <= wr_data;
         end else begin
            r_mem_b[wr_col][wr_row] <= wr_data;
         end
      end
   end

`ifdef MATRIX_SERVER_REQCNT_EN
   logic [15:0] r_req_count;
   assign req_count = r_req_count;
`endif

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state    <= StLoad;
         r_row_addr <= '0;
         r_col_addr <= '0;
         r_complete <= 1'b0;
         r_val_rows <= 1'b0;
         r_wr_err   <= 1'b0;
         r_row_in   <= '0;
         r_col_in   <= '0;
         r_mat_a    <= '0;
         r_mat_b    <= '0;
`ifdef MATRIX_SERVER_REQCNT_EN
         r_req_count <= '0;
`endif
      end else begin
         r_val_rows <= 1'b0;
         case (r_state)
            StLoad: begin
               // Any write in this cycle lands before the serve phase starts.
               if (load_last) begin
                  r_state    <= StIdle;
                  r_complete <= 1'b1;
               end
            end
            default: begin
               if (wr_en) begin
                  r_wr_err <= 1'b1;
               end
               // load_clear aborts any in-flight response before val_rows is raised.
               if (load_clear) begin
                  r_state    <= StLoad;
                  r_complete <= 1'b0;
               end else begin
                  case (r_state)
                     StIdle: begin
                        if (new_request) begin
                           r_row_addr <= row_req;
                           r_col_addr <= col_req;
                           r_state    <= StFetch;
                        end
                     end
                     StFetch: begin
                        r_mat_a    <= r_mem_a[r_row_addr];
                        r_mat_b    <= r_mem_b[r_col_addr];
                        r_row_in   <= r_row_addr;
                        r_col_in   <= r_col_addr;
                        r_val_rows <= 1'b1;
                        r_state    <= StResp;
                     end
                     StResp:  r_state <= StGap;
                     default: r_state <= StIdle;
                  endcase
               end
            end
         endcase
`ifdef MATRIX_SERVER_REQCNT_EN
         if (load_clear) begin
            r_req_count <= '0;
         end else if ((r_state == StResp) && (r_req_count != 16'hFFFF)) begin
            r_req_count <= r_req_count + 16'd1;
         end
`endif
      end
   end

   assign complete = r_complete;
   assign val_rows = r_val_rows;
   assign wr_err   = r_wr_err;
   assign row_in   = r_row_in;
   assign col_in   = r_col_in;
   assign matA_row = r_mat_a;
   assign matB_col = r_mat_b;

endmodule
